// File: rtl/issue_queue.sv
// In-order issue queue between fetch and decode with N-slot pairing rules.
// Optional performance counters are enabled by defining ISSUE_QUEUE_PERF_EN.
module issue_queue #(
    parameter int DEPTH       = 8,
    parameter int IN_WIDTH    = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int PAYLOAD_W   = 104
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             flush,
    input  logic [IN_WIDTH-1:0]              in_valid,
    input  logic [IN_WIDTH*PAYLOAD_W-1:0]    in_payload,
    input  logic [IN_WIDTH*5-1:0]            in_dest,
    input  logic [IN_WIDTH*5-1:0]            in_src1,
    input  logic [IN_WIDTH*5-1:0]            in_src2,
    input  logic [IN_WIDTH-1:0]              in_is_mem,
    input  logic [IN_WIDTH-1:0]              in_is_spec,
    output logic                             in_ready,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] out_payload,
    input  logic                             out_allowin,
    output logic [$clog2(DEPTH):0]           count
`ifdef ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]                      perf_full_cycles,
    output logic [31:0]                      perf_multi_issue
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PAYLOAD_W-1:0] pl_mem   [DEPTH];
    logic [4:0]           dest_mem [DEPTH];
    logic [4:0]           src1_mem [DEPTH];
    logic [4:0]           src2_mem [DEPTH];
    logic                 mem_mem  [DEPTH];
    logic                 spec_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] n_in, n_out;
    logic             enq_fire;
    logic             hazard;

    logic [IDX_W-1:0] wr_idx  [IN_WIDTH];
    logic [IDX_W-1:0] rd_idx  [ISSUE_WIDTH];
    logic [4:0]       rd_dest [ISSUE_WIDTH];
    logic [4:0]       rd_src1 [ISSUE_WIDTH];
    logic [4:0]       rd_src2 [ISSUE_WIDTH];
    logic             rd_mem  [ISSUE_WIDTH];
    logic             rd_spec [ISSUE_WIDTH];

    // Pointers carry a wrap bit, so their difference spans 0..DEPTH.
    assign count    = tail_q - head_q;
    assign in_ready = (DEPTH - int'(count)) >= IN_WIDTH;
    assign enq_fire = in_ready && in_valid[0];

    genvar gi;
    generate
        for (gi = 0; gi < IN_WIDTH; gi++) begin : g_wr
            assign wr_idx[gi] = IDX_W'(tail_q + PTR_W'(gi));
        end
        for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_rd
            assign rd_idx[gi]  = IDX_W'(head_q + PTR_W'(gi));
            assign rd_dest[gi] = dest_mem[rd_idx[gi]];
            assign rd_src1[gi] = src1_mem[rd_idx[gi]];
            assign rd_src2[gi] = src2_mem[rd_idx[gi]];
            assign rd_mem[gi]  = mem_mem[rd_idx[gi]];
            assign rd_spec[gi] = spec_mem[rd_idx[gi]];
            assign out_payload[gi*PAYLOAD_W +: PAYLOAD_W] = pl_mem[rd_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (in_valid[i]) begin
                    pl_mem[wr_idx[i]]   <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
                    dest_mem[wr_idx[i]] <= in_dest[i*5 +: 5];
                    src1_mem[wr_idx[i]] <= in_src1[i*5 +: 5];
                    src2_mem[wr_idx[i]] <= in_src2[i*5 +: 5];
                    mem_mem[wr_idx[i]]  <= in_is_mem[i];
                    spec_mem[wr_idx[i]] <= in_is_spec[i];
                end
            end
        end
    end

    // Slot k may issue only if every older slot issues and no pairing hazard
    // exists against the entries ahead of it; r0 never creates a RAW hazard.
    always_comb begin
        out_valid = '0;
        hazard    = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (k == 0) begin
                out_valid[0] = (count != '0);
            end else begin
                hazard = 1'b0;
                for (int j = 0; j < k; j++) begin
                    if (rd_dest[j] != 5'd0 &&
                        (rd_dest[j] == rd_src1[k] || rd_dest[j] == rd_src2[k]))
                        hazard = 1'b1;
                end
                out_valid[k] = out_valid[k-1] && (int'(count) > k) &&
                               !rd_mem[k] && !rd_spec[k-1] && !hazard;
            end
        end
    end

    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < IN_WIDTH; i++)
            if (in_valid[i]) n_in = n_in + PTR_ONE;
        for (int k = 0; k < ISSUE_WIDTH; k++)
            if (out_valid[k]) n_out = n_out + PTR_ONE;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (enq_fire)    tail_d = tail_q + n_in;
            if (out_allowin) head_d = head_q + n_out;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifdef ISSUE_QUEUE_PERF_EN
    logic [31:0] perf_full_q, perf_multi_q;

    // Counters survive flush and saturate rather than wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_full_q  <= '0;
            perf_multi_q <= '0;
        end else begin
            if (in_valid[0] && !in_ready && perf_full_q != 32'hFFFF_FFFF)
                perf_full_q <= perf_full_q + 32'd1;
            if (ISSUE_WIDTH > 1 && out_allowin && out_valid[ISSUE_WIDTH > 1 ? 1 : 0] &&
                perf_multi_q != 32'hFFFF_FFFF)
                perf_multi_q <= perf_multi_q + 32'd1;
        end
    end

    assign perf_full_cycles = perf_full_q;
    assign perf_multi_issue = perf_multi_q;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed checks of issue_queue against a queue-based reference model.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 2;
    localparam int OW    = 2;
    localparam int PW    = 104;

    typedef struct {
        logic [PW-1:0] pl;
        logic [4:0]    d;
        logic [4:0]    s1;
        logic [4:0]    s2;
        logic          m;
        logic          sp;
    } ent_t;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             flush = 1'b0;
    logic [IW-1:0]    in_valid = '0;
    logic             out_allowin = 1'b0;
    logic             in_ready;
    logic [OW-1:0]    out_valid;
    logic [OW*PW-1:0] out_payload;
    logic [3:0]       count;

    ent_t lane [IW];
    ent_t q[$];

    logic [IW*PW-1:0] in_payload;
    logic [IW*5-1:0]  in_dest, in_src1, in_src2;
    logic [IW-1:0]    in_is_mem, in_is_spec;

    assign in_payload = {lane[1].pl, lane[0].pl};
    assign in_dest    = {lane[1].d,  lane[0].d};
    assign in_src1    = {lane[1].s1, lane[0].s1};
    assign in_src2    = {lane[1].s2, lane[0].s2};
    assign in_is_mem  = {lane[1].m,  lane[0].m};
    assign in_is_spec = {lane[1].sp, lane[0].sp};

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .IN_WIDTH(IW), .ISSUE_WIDTH(OW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload),
        .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
        .in_is_mem(in_is_mem), .in_is_spec(in_is_spec),
        .in_ready(in_ready), .out_valid(out_valid), .out_payload(out_payload),
        .out_allowin(out_allowin), .count(count)
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2,
                            input logic m, input logic sp);
        logic [71:0] hi;
        hi = {8'($urandom()), $urandom(), $urandom()};
        lane[i].pl = {hi, pc};
        lane[i].d  = d;
        lane[i].s1 = s1;
        lane[i].s2 = s2;
        lane[i].m  = m;
        lane[i].sp = sp;
    endtask

    // Reference pairing: slot k joins the issue group only if the whole
    // older group issues and the rules hold against the queued entries.
    function automatic logic [OW-1:0] model_ov();
        logic [OW-1:0] ov;
        logic          raw;
        ov = '0;
        if (q.size() >= 1) ov[0] = 1'b1;
        for (int k = 1; k < OW; k++) begin
            raw = 1'b0;
            if (q.size() > k) begin
                for (int j = 0; j < k; j++)
                    if (q[j].d != 0 && (q[j].d == q[k].s1 || q[j].d == q[k].s2)) raw = 1'b1;
                ov[k] = ov[k-1] && !q[k].m && !q[k-1].sp && !raw;
            end
        end
        return ov;
    endfunction

    // Check all outputs against the model, then advance one clock.
    task automatic cycle();
        logic [OW-1:0] ov;
        int            nout;
        logic          rdy;
        ov  = model_ov();
        rdy = (DEPTH - q.size()) >= IW;
        chk("count", PW'(count), PW'(q.size()));
        chk("in_ready", PW'(in_ready), PW'(rdy));
        chk("out_valid", PW'(out_valid), PW'(ov));
        for (int k = 0; k < OW; k++)
            if (ov[k]) chk($sformatf("payload%0d", k), out_payload[k*PW +: PW], q[k].pl);
        $display("t=%0t v=%b allow=%b flush=%b count=%0d out_valid=%b", $time,
                 in_valid, out_allowin, flush, count, out_valid);
        nout = 0;
        for (int k = 0; k < OW; k++) if (ov[k]) nout++;
        if (flush) begin
            q.delete();
        end else begin
            if (out_allowin) repeat (nout) void'(q.pop_front());
            if (rdy && in_valid[0])
                for (int i = 0; i < IW; i++) if (in_valid[i]) q.push_back(lane[i]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = '0;
        flush    = 1'b0;
    endtask

    initial begin
        set_lane(0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        set_lane(1, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_count", PW'(count), PW'(0));
        chk("reset_ready", PW'(in_ready), PW'(1));
        resetn = 1'b1;
        @(negedge clk);

        // Independent ALU pair dual-issues, queue drains.
        out_allowin = 1'b1;
        set_lane(0, 32'h1c000000, 5'd4, 5'd1, 5'd2, 1'b0, 1'b0);
        set_lane(1, 32'h1c000004, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
        in_valid = 2'b11;
        cycle();
        idle();
        chk("pair_ov", PW'(out_valid), PW'(2'b11));
        cycle();
        chk("pair_drained", PW'(count), PW'(0));

        // RAW hazard splits the pair; r0 never conflicts.
        set_lane(0, 32'h1c000008, 5'd4, 5'd1, 5'd2, 1'b0, 1'b0);
        set_lane(1, 32'h1c00000c, 5'd6, 5'd4, 5'd2, 1'b0, 1'b0);
        in_valid = 2'b11;
        cycle();
        idle();
        chk("raw_ov0", PW'(out_valid), PW'(2'b01));
        cycle();
        chk("raw_ov1", PW'(out_valid), PW'(2'b01));
        cycle();
        set_lane(0, 32'h1c000010, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
        set_lane(1, 32'h1c000014, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        in_valid = 2'b11;
        cycle();
        idle();
        chk("r0_ov", PW'(out_valid), PW'(2'b11));
        cycle();

        // Memory op in slot 1, then special op in slot 0.
        set_lane(0, 32'h1c000018, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
        set_lane(1, 32'h1c00001c, 5'd8, 5'd1, 5'd2, 1'b1, 1'b0);
        in_valid = 2'b11;
        cycle();
        idle();
        chk("mem_ov", PW'(out_valid), PW'(2'b01));
        cycle();
        cycle();
        set_lane(0, 32'h1c000020, 5'd7, 5'd1, 5'd2, 1'b0, 1'b1);
        set_lane(1, 32'h1c000024, 5'd8, 5'd1, 5'd2, 1'b0, 1'b0);
        in_valid = 2'b11;
        cycle();
        idle();
        chk("spec_ov", PW'(out_valid), PW'(2'b01));
        cycle();
        cycle();

        // Fill to full with downstream stalled; fifth pair is ignored.
        out_allowin = 1'b0;
        for (int p = 0; p < 5; p++) begin
            set_lane(0, 32'h1c000100 + 32'(p*8), 5'd10, 5'd1, 5'd2, 1'b0, 1'b0);
            set_lane(1, 32'h1c000104 + 32'(p*8), 5'd11, 5'd1, 5'd2, 1'b0, 1'b0);
            in_valid = 2'b11;
            cycle();
        end
        idle();
        chk("full_count", PW'(count), PW'(8));
        chk("full_ready", PW'(in_ready), PW'(0));
        out_allowin = 1'b1;
        repeat (4) cycle();
        set_lane(0, 32'h1c000200, 5'd12, 5'd1, 5'd2, 1'b0, 1'b0);
        set_lane(1, 32'h1c000204, 5'd13, 5'd1, 5'd2, 1'b0, 1'b0);
        in_valid = 2'b11;
        cycle();
        idle();
        cycle();

        // Count 6 with simultaneous enqueue/dequeue, then flush.
        out_allowin = 1'b0;
        for (int p = 0; p < 3; p++) begin
            set_lane(0, 32'h1c000300 + 32'(p*8), 5'd14, 5'd1, 5'd2, 1'b0, 1'b0);
            set_lane(1, 32'h1c000304 + 32'(p*8), 5'd15, 5'd1, 5'd2, 1'b0, 1'b0);
            in_valid = 2'b11;
            cycle();
        end
        out_allowin = 1'b1;
        cycle();
        chk("steady_count", PW'(count), PW'(6));
        flush = 1'b1;
        cycle();
        idle();
        chk("flush_count", PW'(count), PW'(0));
        chk("flush_ov", PW'(out_valid), PW'(0));

        // Asynchronous reset with five entries held.
        out_allowin = 1'b0;
        in_valid = 2'b11; cycle();
        in_valid = 2'b11; cycle();
        in_valid = 2'b01; cycle();
        idle();
        chk("pre_reset_count", PW'(count), PW'(5));
        #2 resetn = 1'b0;
        #1;
        chk("async_count", PW'(count), PW'(0));
        chk("async_ov", PW'(out_valid), PW'(0));
        chk("async_ready", PW'(in_ready), PW'(1));
        q.delete();
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic with small register range to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < IW; i++)
                set_lane(i, $urandom(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                         ($urandom_range(0, 4) == 0));
            case ($urandom_range(0, 2))
                0: in_valid = 2'b00;
                1: in_valid = 2'b01;
                default: in_valid = 2'b11;
            endcase
            out_allowin = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised successor to the fixed two-slot decode/issue pairing logic.
- Circular buffer between fetch and decode: accepts up to IN_WIDTH fetched instructions per cycle, holds DEPTH entries, and issues up to ISSUE_WIDTH in order per cycle.
- Issue-slot pairing rules (RAW, memory-op, special-op) are generalised to N slots and evaluated on buffered entries, which decouples fetch bubbles from decode.

Parameters:
DEPTH, 8, entry count; power of two, >= 2*IN_WIDTH
IN_WIDTH, 2, max instructions enqueued per cycle
ISSUE_WIDTH, 2, max instructions issued per cycle, 1..4
PAYLOAD_W, 104, opaque per-entry payload width (pc, inst, pred taken/target, exception flag/type)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  discard all contents (branch mispredict / exception)
in_valid  in  IN_WIDTH  per-lane valid; must be contiguous from bit 0
in_payload  in  IN_WIDTH*PAYLOAD_W  lane payloads, lane 0 = oldest
in_dest  in  IN_WIDTH*5  destination register per lane
in_src1  in  IN_WIDTH*5  source register 1 per lane
in_src2  in  IN_WIDTH*5  source register 2 per lane
in_is_mem  in  IN_WIDTH  lane is load/store
in_is_spec  in  IN_WIDTH  lane is CSR/barrier/special op
in_ready  out  1  queue can take a full IN_WIDTH group this cycle
out_valid  out  ISSUE_WIDTH  slot k holds an issuable instruction; thermometer-coded
out_payload  out  ISSUE_WIDTH*PAYLOAD_W  slot payloads, slot 0 = oldest
out_allowin  in  1  downstream accepts every asserted out_valid slot this cycle
count  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry array. Head/tail pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit. Full when pointers differ only in the MSB; empty when equal.
- Reset (resetn low, asynchronous): head = tail = 0, count = 0, out_valid = 0, in_ready = 1. Array contents are don't-care. Reset mid-operation discards everything; first enqueue after release lands at index 0.
- in_ready = (DEPTH - count) >= IN_WIDTH. Computed from the current count only; same-cycle dequeues are not credited.
- Enqueue fires when in_ready && in_valid[0]:
  - writes popcount(in_valid) lanes at tail, tail to tail+n, in lane order;
  - in_valid driven while in_ready = 0 is ignored (no partial accept).
- Issue selection (combinational from entries head..head+ISSUE_WIDTH-1):
  - slot 0 valid iff count >= 1;
  - slot k (k >= 1) valid iff slot k-1 valid, count > k, entry k not is_mem, entry k-1 not is_spec, and no earlier slot j < k has dest != 0 matching src1 or src2 of entry k.
- Dequeue: when out_allowin, head advances by popcount(out_valid); out_valid = 0 dequeues nothing.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + n_in - n_out. Pointers wrap modulo 2*DEPTH.
- Flush: takes priority over enqueue and dequeue in the same cycle. Next edge gives head = tail = 0, count = 0; out_valid is 0 in the following cycle.
- Latency: an entry enqueued at edge t is visible on out_valid after edge t (one cycle). There is no bypass from in_* to out_*.
- out_payload of invalid slots is don't-care.

Optional Feature:
ISSUE_QUEUE_PERF_EN:
- Defined: adds outputs perf_full_cycles [31:0] and perf_multi_issue [31:0].
  - perf_full_cycles: cycles with in_valid[0] && !in_ready.
  - perf_multi_issue: cycles with out_allowin && out_valid[1].
  - Both clear on reset, saturate at 32'hFFFFFFFF, and are not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then enqueue pc 0x1c000000/0x1c000004 ALU ops with independent regs (dest r4,r5; srcs r1,r2), out_allowin = 1 -> next cycle out_valid = 2'b11; following cycle count = 0.
- Enqueue pair where lane 0 dest = r4 and lane 1 src1 = r4 -> out_valid = 2'b01, then 2'b01 on the next cycle; a dest = r0 match gives 2'b11.
- Lane 1 is_mem = 1 or lane 0 is_spec = 1 -> out_valid = 2'b01 only.
- Hold out_allowin = 0 while enqueuing 4 pairs (DEPTH = 8) -> count = 8, in_ready = 0. A 5th pair is ignored. Release -> in-order drain; tail wraps to index 0 and the next pair is accepted correctly.
- Count = 6 with out_allowin = 1 and a pair enqueued in the same cycle -> count = 6 - 2 + 2 = 6; flush asserted in that cycle instead -> count = 0 and out_valid = 0 next cycle.
- Assert resetn low mid-drain (count = 5) -> count = 0 and out_valid = 0 immediately, without a clock edge.
